// File: rtl/ik_swift_st_pkg.sv
// ---------------------------------------------------------------------------
// ik_swift_st_pkg
// Shared definitions for the ik_swift Avalon-ST blocks.
//   ik_log2()                      : ceiling log2 of a positive integer
//   ik_fill_w()                    : bit width needed to hold 0..depth
//   IK_SWIFT_ST_MAX_READY_LATENCY  : largest upstream ready latency supported
//   ik_fifo_flags_t                : empty/full status pair of a FIFO
// ---------------------------------------------------------------------------
package ik_swift_st_pkg;

    localparam int IK_SWIFT_ST_MAX_READY_LATENCY = 3;

    typedef struct packed {
        logic empty;
        logic full;
    } ik_fifo_flags_t;

    function automatic int ik_log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // An occupancy counter must reach depth itself, hence the extra bit.
    function automatic int ik_fill_w(input int depth);
        return ik_log2(depth) + 1;
    endfunction

endpackage

// File: rtl/ik_swift_st_timing_adapter_if.sv
// ---------------------------------------------------------------------------
// ik_swift_st_timing_adapter_if
// One Avalon-ST beat channel (valid/data/ready).
//   master : drives valid and data, receives ready
//   slave  : receives valid and data, drives ready
// ---------------------------------------------------------------------------
interface ik_swift_st_timing_adapter_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ik_swift_st_fifo_regs.sv
// ---------------------------------------------------------------------------
// ik_swift_st_fifo_regs
// Register-array FIFO with show-ahead read data.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   push, push_data       : write request and payload
//   pop                   : read request (ignored while empty)
//   rd_data               : entry at the read pointer (combinational)
//   full, empty           : status flags
//   level                 : occupancy 0..DEPTH
// A push while full is only accepted if a pop happens in the same cycle;
// otherwise it is dropped and the state is left untouched.
// ---------------------------------------------------------------------------
module ik_swift_st_fifo_regs
    import ik_swift_st_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int LW    = ik_fill_w(DEPTH),
    localparam int PW    = (DEPTH > 1) ? ik_log2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [LW-1:0]     level
);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [LW-1:0]     count;
    logic              do_push;
    logic              do_pop;
    ik_fifo_flags_t    flags;

    assign flags.empty = (count == '0);
    assign flags.full  = (count == DEPTH_L);
    assign empty       = flags.empty;
    assign full        = flags.full;
    assign level       = count;
    assign rd_data     = mem[rd_ptr];

    assign do_pop  = pop && !flags.empty;
    // The slot freed by a same-cycle pop makes a push into a full FIFO legal.
    assign do_push = push && (!flags.full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ik_swift_st_timing_adapter.sv
// ---------------------------------------------------------------------------
// ik_swift_st_timing_adapter
// Avalon-ST timing adapter from an upstream source with ready latency
// IN_READY_LATENCY to a ready-latency-0 sink. A register FIFO holds the
// beats still in flight when the sink stalls.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   in_st        : upstream channel (slave); ready is a space grant, the
//                  matching beat may arrive IN_READY_LATENCY cycles later
//   out_st       : downstream channel (master), show-ahead data
//   fill_level   : FIFO occupancy 0..DEPTH
//   overflow     : sticky flag for a beat arriving with nowhere to go
// Optional feature macro: IK_SWIFT_TADT_OVF_CHECK_EN enables the overflow
// checker and its simulation message; otherwise overflow is tied low.
// ---------------------------------------------------------------------------
module ik_swift_st_timing_adapter
    import ik_swift_st_pkg::*;
#(
    parameter int DATA_W           = 8,
    parameter int IN_READY_LATENCY = 0,
    parameter int DEPTH            = 4,
    localparam int FW              = ik_fill_w(DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    ik_swift_st_timing_adapter_if.slave   in_st,
    ik_swift_st_timing_adapter_if.master  out_st,
    output logic [FW-1:0]                 fill_level,
    output logic                          overflow
);

    if (IN_READY_LATENCY < 0 || IN_READY_LATENCY > IK_SWIFT_ST_MAX_READY_LATENCY) begin : g_bad_latency
        $error("IN_READY_LATENCY must be in 0..%0d", IK_SWIFT_ST_MAX_READY_LATENCY);
    end
    if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth_pow2
        $error("DEPTH must be a power of 2");
    end
    if (DEPTH < IN_READY_LATENCY + 1) begin : g_bad_depth_small
        $error("DEPTH must be at least IN_READY_LATENCY+1");
    end

    logic [FW-1:0] level;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    ik_swift_st_fifo_regs #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (in_st.valid),
        .push_data (in_st.data),
        .pop       (pop),
        .rd_data   (out_st.data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign out_st.valid = !fifo_empty;
    assign pop          = !fifo_empty && out_st.ready;
    assign fill_level   = level;

    // Only grant while the current grant plus up to L beats already granted
    // but not yet arrived still fit. Driven from the registered count only.
    assign in_st.ready  = (int'(level) + IN_READY_LATENCY) < DEPTH;

`ifdef IK_SWIFT_TADT_OVF_CHECK_EN
    logic viol;
    logic overflow_q;

    assign viol     = in_st.valid && fifo_full && !pop;
    assign overflow = overflow_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (viol) begin
            overflow_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset_n && viol) begin
            $display("%m: beat dropped, upstream wrote into a full FIFO");
        end
    end
`endif
`else
    wire unused_fifo_full = fifo_full;
    assign overflow = 1'b0;
`endif

endmodule
